// File: rtl/regfile_write_scheduler.sv
// Write-port controller for the register file: long-latency busy scoreboard
// with issue hazard stall, plus ALU/long-unit write arbitration with anti-starvation.
module regfile_write_scheduler #(
  parameter int NUM_REGS     = 32,
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  // decode / issue
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_rs,
  input  logic [ADDR_W-1:0]   issue_rt,
  input  logic                issue_uses_rt,
  input  logic [ADDR_W-1:0]   issue_rd,
  input  logic                issue_long,
  output logic                issue_stall,
  // in-order ALU writeback
  input  logic                alu_wb_valid,
  input  logic [ADDR_W-1:0]   alu_wb_reg,
  input  logic [DATA_W-1:0]   alu_wb_data,
  output logic                alu_wb_ready,
  // long-latency unit writeback
  input  logic                long_wb_valid,
  input  logic [ADDR_W-1:0]   long_wb_reg,
  input  logic [DATA_W-1:0]   long_wb_data,
  output logic                long_wb_ready,
  // register file write port
  output logic                rf_write_enable,
  output logic [ADDR_W-1:0]   rf_write_reg,
  output logic [DATA_W-1:0]   rf_write_data,
  output logic [NUM_REGS-1:0] busy_vec
);

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LONG = 2'd2
  } wb_src_e;

  localparam logic [3:0] STARVE_MAX = 4'hF;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [3:0]          starve_cnt_q, starve_cnt_d;
  wb_src_e             grant_src;
  logic                force_long;
  logic                rs_hazard, rt_hazard, rd_hazard;
  logic                issue_accept;
  logic [ADDR_W-1:0]   wb_reg;
  logic [DATA_W-1:0]   wb_data;

  // ---------------------------------------------------------------------------
  // Hazard detection against the registered scoreboard only; a clear landing
  // this cycle is deliberately not bypassed, so release lags the grant by one.
  // ---------------------------------------------------------------------------
  assign rs_hazard    = busy_q[issue_rs];
  assign rt_hazard    = issue_uses_rt && busy_q[issue_rt];
  assign rd_hazard    = busy_q[issue_rd];
  assign issue_stall  = issue_valid && (rs_hazard || rt_hazard || rd_hazard);
  assign issue_accept = issue_valid && !issue_stall && issue_long
                        && (issue_rd != '0);

  // ---------------------------------------------------------------------------
  // Arbitration: ALU has fixed priority unless the long request has been
  // passed over STARVE_LIMIT times in a row.
  // ---------------------------------------------------------------------------
  assign force_long = (starve_cnt_q >= STARVE_LIM);

  always_comb begin
    // NOTE: every always_comb output is given a default first so no path
    // through the block can infer a latch.
    grant_src = SRC_NONE;
    wb_reg    = alu_wb_reg;
    wb_data   = alu_wb_data;
    if (long_wb_valid && (force_long || !alu_wb_valid)) begin
      grant_src = SRC_LONG;
      wb_reg    = long_wb_reg;
      wb_data   = long_wb_data;
    end else if (alu_wb_valid) begin
      grant_src = SRC_ALU;
    end
  end

  assign alu_wb_ready  = (grant_src == SRC_ALU);
  assign long_wb_ready = (grant_src == SRC_LONG);

  // Starvation counter only measures an uninterrupted run of lost cycles.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!long_wb_valid || (grant_src == SRC_LONG)) begin
      starve_cnt_d = '0;
    end else if ((grant_src == SRC_ALU) && (starve_cnt_q != STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard update. A same-index set and clear cannot both be legal since
  // a busy rd stalls issue; different indices both take effect.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d = busy_q;
    if (issue_accept) begin
      busy_d[issue_rd] = 1'b1;
    end
    if (grant_src == SRC_LONG) begin
      busy_d[long_wb_reg] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the scoreboard is flops, not RAM, and must be reset: a stale busy
    // bit after reset would stall issue forever since no writeback will clear it.
    if (!rst_n) begin
      busy_q       <= '0;
      starve_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      busy_q       <= busy_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Write port: one-cycle registered latency; reg/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_write_enable <= 1'b0;
      rf_write_reg    <= '0;
      rf_write_data   <= '0;
    end else if (grant_src != SRC_NONE) begin
      rf_write_enable <= (wb_reg != '0);
      rf_write_reg    <= wb_reg;
      rf_write_data   <= wb_data;
    end else begin
      rf_write_enable <= 1'b0;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed self-checking bench for regfile_write_scheduler: reset, RAW/WAW
// scoreboard stalls, write latency, anti-starvation and register 0 handling.
module tb_regfile_write_scheduler;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                issue_valid;
  logic [ADDR_W-1:0]   issue_rs, issue_rt, issue_rd;
  logic                issue_uses_rt, issue_long;
  logic                issue_stall;
  logic                alu_wb_valid;
  logic [ADDR_W-1:0]   alu_wb_reg;
  logic [DATA_W-1:0]   alu_wb_data;
  logic                alu_wb_ready;
  logic                long_wb_valid;
  logic [ADDR_W-1:0]   long_wb_reg;
  logic [DATA_W-1:0]   long_wb_data;
  logic                long_wb_ready;
  logic                rf_write_enable;
  logic [ADDR_W-1:0]   rf_write_reg;
  logic [DATA_W-1:0]   rf_write_data;
  logic [NUM_REGS-1:0] busy_vec;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_write_scheduler #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_uses_rt(issue_uses_rt), .issue_rd(issue_rd), .issue_long(issue_long),
    .issue_stall(issue_stall),
    .alu_wb_valid(alu_wb_valid), .alu_wb_reg(alu_wb_reg),
    .alu_wb_data(alu_wb_data), .alu_wb_ready(alu_wb_ready),
    .long_wb_valid(long_wb_valid), .long_wb_reg(long_wb_reg),
    .long_wb_data(long_wb_data), .long_wb_ready(long_wb_ready),
    .rf_write_enable(rf_write_enable), .rf_write_reg(rf_write_reg),
    .rf_write_data(rf_write_data), .busy_vec(busy_vec)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    issue_valid   = 1'b0;
    issue_rs      = '0;
    issue_rt      = '0;
    issue_rd      = '0;
    issue_uses_rt = 1'b0;
    issue_long    = 1'b0;
    alu_wb_valid  = 1'b0;
    alu_wb_reg    = '0;
    alu_wb_data   = '0;
    long_wb_valid = 1'b0;
    long_wb_reg   = '0;
    long_wb_data  = '0;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt,
                       input logic uses_rt, input logic [ADDR_W-1:0] rd,
                       input logic is_long);
    issue_valid   = 1'b1;
    issue_rs      = rs;
    issue_rt      = rt;
    issue_uses_rt = uses_rt;
    issue_rd      = rd;
    issue_long    = is_long;
  endtask

  task automatic alu_req(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    alu_wb_valid = 1'b1;
    alu_wb_reg   = r;
    alu_wb_data  = d;
  endtask

  task automatic long_req(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    long_wb_valid = 1'b1;
    long_wb_reg   = r;
    long_wb_data  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Inputs change and outputs are sampled on the falling edge, clear of posedge.
  initial begin
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    check("reset_busy", busy_vec, 0);
    check("reset_en", rf_write_enable, 0);
    check("reset_reg", rf_write_reg, 0);
    check("reset_data", rf_write_data, 0);
    rst_n = 1'b1;

    // Build some state, then reset asynchronously mid-cycle with traffic.
    @(negedge clk);
    issue(5'd0, 5'd0, 1'b0, 5'd4, 1'b1);
    alu_req(5'd7, 32'h11);
    @(negedge clk);
    check("pre_rst_busy", busy_vec, 32'h10);
    check("pre_rst_en", rf_write_enable, 1);
    issue(5'd4, 5'd0, 1'b0, 5'd6, 1'b0);
    long_req(5'd4, 32'h44);
    #1;
    check("pre_rst_stall", issue_stall, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy_vec, 0);
    check("async_rst_en", rf_write_enable, 0);
    check("async_rst_data", rf_write_data, 0);
    check("rst_stall", issue_stall, 0);
    check("rst_alu_ready", alu_wb_ready, 1);
    check("rst_long_ready", long_wb_ready, 0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;

    // Write latency: grant at N, write visible at N+1, enable drops at N+2.
    @(negedge clk);
    alu_req(5'd7, 32'hDEADBEEF);
    #1;
    check("lat_alu_ready", alu_wb_ready, 1);
    check("lat_long_ready", long_wb_ready, 0);
    @(negedge clk);
    idle();
    check("lat_en_n1", rf_write_enable, 1);
    check("lat_reg_n1", rf_write_reg, 7);
    check("lat_data_n1", rf_write_data, 32'hDEADBEEF);
    @(negedge clk);
    check("lat_en_n2", rf_write_enable, 0);
    check("lat_reg_hold", rf_write_reg, 7);
    check("lat_data_hold", rf_write_data, 32'hDEADBEEF);

    // RAW on a pending long result.
    issue(5'd1, 5'd2, 1'b1, 5'd5, 1'b1);
    #1;
    check("raw_issue_stall", issue_stall, 0);
    @(negedge clk);
    check("raw_busy_set", busy_vec, 32'h20);
    issue(5'd5, 5'd0, 1'b0, 5'd6, 1'b0);
    #1;
    check("raw_rs_stall", issue_stall, 1);
    @(negedge clk);
    check("raw_busy_hold", busy_vec, 32'h20);
    issue(5'd1, 5'd5, 1'b0, 5'd6, 1'b0);
    #1;
    check("raw_rt_unused", issue_stall, 0);
    issue_uses_rt = 1'b1;
    #1;
    check("raw_rt_used", issue_stall, 1);
    @(negedge clk);
    issue(5'd5, 5'd0, 1'b0, 5'd6, 1'b0);
    long_req(5'd5, 32'hCAFE);
    #1;
    check("raw_long_ready", long_wb_ready, 1);
    check("raw_stall_grant_cycle", issue_stall, 1);
    @(negedge clk);
    long_wb_valid = 1'b0;
    check("raw_busy_clear", busy_vec, 0);
    check("raw_wr_en", rf_write_enable, 1);
    check("raw_wr_reg", rf_write_reg, 5);
    check("raw_wr_data", rf_write_data, 32'hCAFE);
    #1;
    check("raw_stall_release", issue_stall, 0);
    @(negedge clk);
    idle();

    // Anti-starvation: ALU wins three cycles, long forced on the fourth.
    issue(5'd0, 5'd0, 1'b0, 5'd9, 1'b1);
    @(negedge clk);
    idle();
    check("starve_busy9", busy_vec, 32'h200);
    long_req(5'd9, 32'h1234);
    for (int i = 0; i < 3; i++) begin
      alu_req(5'(10 + i), 32'hA0 + i);
      #1;
      check($sformatf("starve_alu_win%0d", i), alu_wb_ready, 1);
      check($sformatf("starve_long_lose%0d", i), long_wb_ready, 0);
      @(negedge clk);
      check($sformatf("starve_wr_reg%0d", i), rf_write_reg, 10 + i);
    end
    alu_req(5'd13, 32'hA3);
    #1;
    check("starve_alu_forced_off", alu_wb_ready, 0);
    check("starve_long_forced", long_wb_ready, 1);
    @(negedge clk);
    check("starve_wr_reg9", rf_write_reg, 9);
    check("starve_wr_data", rf_write_data, 32'h1234);
    check("starve_busy_clear", busy_vec, 0);
    long_req(5'd9, 32'h5678);
    #1;
    check("starve_cnt_restart", alu_wb_ready, 1);
    @(negedge clk);
    idle();
    check("starve_wr_reg13", rf_write_reg, 13);

    // Register 0: never busy, grant completes, no write enable.
    issue(5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
    @(negedge clk);
    idle();
    check("r0_busy", busy_vec, 0);
    alu_req(5'd0, 32'hFFFF);
    #1;
    check("r0_alu_ready", alu_wb_ready, 1);
    @(negedge clk);
    idle();
    check("r0_wr_en", rf_write_enable, 0);

    // WAW with same-cycle clear, then re-issue; different-index set/clear.
    issue(5'd0, 5'd0, 1'b0, 5'd3, 1'b1);
    @(negedge clk);
    check("waw_busy3", busy_vec, 32'h8);
    issue(5'd1, 5'd0, 1'b0, 5'd3, 1'b1);
    #1;
    check("waw_stall", issue_stall, 1);
    @(negedge clk);
    long_req(5'd3, 32'h33);
    #1;
    check("waw_long_ready", long_wb_ready, 1);
    check("waw_stall_grant_cycle", issue_stall, 1);
    @(negedge clk);
    long_wb_valid = 1'b0;
    check("waw_busy_clear", busy_vec, 0);
    check("waw_wr_reg", rf_write_reg, 3);
    #1;
    check("waw_stall_release", issue_stall, 0);
    @(negedge clk);
    idle();
    check("waw_reissue_busy", busy_vec, 32'h8);
    issue(5'd0, 5'd0, 1'b0, 5'd8, 1'b1);
    long_req(5'd3, 32'h77);
    @(negedge clk);
    idle();
    check("set_clear_diff", busy_vec, 32'h100);
    check("set_clear_wr_data", rf_write_data, 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
Controller in front of the 32x32 register file's single write port. It keeps a per-register busy scoreboard for long-latency results (mul/div/load-miss) and stalls issue on RAW/WAW hazards against pending registers. It also arbitrates the write port between the in-order ALU writeback stream and the long-latency unit, with fixed ALU priority and anti-starvation. It sits between decode/issue, the two writeback sources, and the register file write inputs (write_enable/write_reg/write_data).

Parameters:
NUM_REGS, 32, number of architectural registers; register 0 is hard-wired zero
ADDR_W, 5, register address width (log2 NUM_REGS)
DATA_W, 32, write data width
STARVE_LIMIT, 3, consecutive cycles a waiting long request may lose before it gets forced priority (legal range 1..15)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
issue_valid  input  1  decode presents an instruction this cycle
issue_rs  input  ADDR_W  source register 1
issue_rt  input  ADDR_W  source register 2
issue_uses_rt  input  1  rt is a true source and takes part in hazard checking
issue_rd  input  ADDR_W  destination register
issue_long  input  1  result will be produced by the long-latency unit
issue_stall  output  1  combinational; hold decode this cycle
alu_wb_valid  input  1  ALU writeback request
alu_wb_reg  input  ADDR_W  ALU destination
alu_wb_data  input  DATA_W  ALU result
alu_wb_ready  output  1  combinational grant to ALU
long_wb_valid  input  1  long unit writeback request; held stable until granted
long_wb_reg  input  ADDR_W  long unit destination
long_wb_data  input  DATA_W  long unit result
long_wb_ready  output  1  combinational grant to long unit
rf_write_enable  output  1  registered write enable to the register file
rf_write_reg  output  ADDR_W  registered write address
rf_write_data  output  DATA_W  registered write data
busy_vec  output  NUM_REGS  registered scoreboard; bit i set means register i awaits a long result

Behaviour:
- Reset (async, rst_n=0): busy_vec=0, starve_cnt=0, rf_write_enable=0, rf_write_reg=0, rf_write_data=0. The combinational outputs follow from the reset state: issue_stall=0 when issue_valid=0, alu_wb_ready=alu_wb_valid, long_wb_ready=long_wb_valid && !alu_wb_valid.
- Hazard: issue_stall = issue_valid && (busy[rs] || (issue_uses_rt && busy[rt]) || busy[rd]).
- Busy bit 0 always reads 0 and is never set.
- Stall uses the current registered busy_vec only. A clear occurring in the same cycle is not bypassed, so the stall releases one cycle after the clearing grant.
- Issue accept (issue_valid && !issue_stall && issue_long && rd!=0): set busy[rd] on the next edge.
- Arbitration:
  - force = (starve_cnt >= STARVE_LIMIT).
  - If long_wb_valid && (force || !alu_wb_valid): grant long. Otherwise, if alu_wb_valid: grant ALU.
  - At most one grant per cycle.
- starve_cnt:
  - Increments (saturating at 15) when long_wb_valid && alu granted.
  - Resets to 0 on a long grant, or when long_wb_valid=0.
- Long grant: clear busy[long_wb_reg] on the next edge.
- Set/clear interaction: a set and a clear of the same index in one cycle cannot both be legal, because a busy rd stalls issue. For a set and a clear on different indices, both take effect.
- Write port latency: one cycle. On the edge after a grant, rf_write_enable=1 and rf_write_reg/rf_write_data take the granted source's values. With no grant, rf_write_enable=0 and reg/data hold their previous values.
- A granted write to register 0 produces rf_write_enable=0 (the grant still completes the handshake).
- ALU writes to a busy register: forwarded unchanged; hazard avoidance is the issue stall's responsibility.
- A long writeback to a register whose busy bit is already clear is still written and is harmless.
- Reset mid-operation: all pending busy bits drop and any pending write is discarded. The upstream units are reset by the same rst_n.

Test Plan:
1. Reset: rst_n=0 with traffic on all inputs -> busy_vec=0, rf_write_enable=0 immediately, asynchronously, without waiting for a clock edge.
2. Scoreboard RAW: issue long rd=5 -> busy_vec[5]=1. Next, issue rs=5 -> issue_stall=1 until long_wb grant to reg 5. busy[5] clears one edge after the grant; stall drops the following cycle.
3. Write latency: alu_wb_valid, reg=7, data=0xDEADBEEF at cycle N -> alu_wb_ready=1 at N; rf_write_enable=1, reg=7, data=0xDEADBEEF at N+1; enable=0 at N+2.
4. Anti-starvation: alu_wb_valid=1 every cycle with long_wb_valid=1 (reg=9, data=0x1234) and STARVE_LIMIT=3 -> ALU wins 3 cycles, long wins 4th cycle (alu_wb_ready=0), starve_cnt returns to 0, busy[9] clears.
5. Register 0: issue long rd=0 -> busy_vec unchanged. ALU wb to reg 0 -> alu_wb_ready=1, rf_write_enable stays 0.
6. WAW: rd=3 busy, issue long rd=3 -> stalled. Same-cycle long grant of reg 3 -> stall still 1 that cycle, 0 next cycle; reissue sets busy[3] again.
